// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory responder: FSM state encoding
// and default word/address geometry.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         DEF_WIDTH     = 32;
    localparam int         DEF_ADDRSIZE  = 12;
    localparam logic [6:0] DEF_HALT_CODE = 7'd5;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Bus bundle between the CPU/loader/dump-sink side (master) and the memory
// responder (slave).
interface cpu_mem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) ();

    logic [ADDRSIZE-1:0] MEM_ADDR;
    logic [0:WIDTH-1]    MEM_IN;
    logic [0:WIDTH-1]    MEM_OUT;
    logic                MEM_CTRL;
    logic [ADDRSIZE-1:0] INS_ADDR;
    logic [0:WIDTH-1]    INS_MEM;
    logic [6:0]          debuger;

    logic                ld_valid;
    logic                ld_sel;
    logic [WIDTH-1:0]    ld_data;
    logic                ld_last;
    logic                ld_ready;
    logic                cpu_hold;

    logic                dump_valid;
    logic [ADDRSIZE-1:0] dump_addr;
    logic [WIDTH-1:0]    dump_data;
    logic                dump_ready;
    logic                halted;

    modport slave (
        input  MEM_ADDR, MEM_OUT, MEM_CTRL, INS_ADDR, debuger,
        input  ld_valid, ld_sel, ld_data, ld_last, dump_ready,
        output MEM_IN, INS_MEM, ld_ready, cpu_hold,
        output dump_valid, dump_addr, dump_data, halted
    );

    modport master (
        output MEM_ADDR, MEM_OUT, MEM_CTRL, INS_ADDR, debuger,
        output ld_valid, ld_sel, ld_data, ld_last, dump_ready,
        input  MEM_IN, INS_MEM, ld_ready, cpu_hold,
        input  dump_valid, dump_addr, dump_data, halted
    );

endinterface

// File: rtl/cpu_mem_array.sv
// Word-addressed memory: one synchronous write port and RD_PORTS combinational
// read ports. Contents are never reset.
module cpu_mem_array #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int RD_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [ADDRSIZE-1:0]                waddr,
    input  logic [WIDTH-1:0]                   wdata,
    input  logic [RD_PORTS-1:0][ADDRSIZE-1:0]  raddr,
    output logic [RD_PORTS-1:0][WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [0:(2**ADDRSIZE)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        assign rdata[i] = mem[raddr[i]];
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Data/instruction memory responder for the CPU: loads both memories while the
// CPU is held, serves it while running, then streams out data words on halt.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int         WIDTH      = DEF_WIDTH,
    parameter int         ADDRSIZE   = DEF_ADDRSIZE,
    parameter int         DUMP_WORDS = 10,
    parameter logic [6:0] HALT_CODE  = DEF_HALT_CODE
) (
    input logic                 clk,
    input logic                 rst,
    cpu_mem_responder_if.slave  bus
);

    localparam logic [ADDRSIZE-1:0] DUMP_LAST = ADDRSIZE'(DUMP_WORDS - 1);

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] dld_cnt_q, ild_cnt_q, dump_cnt_q;
    logic                ld_fire, dump_fire, cpu_we;

    logic                             dmem_we, imem_we;
    logic [ADDRSIZE-1:0]              dmem_waddr;
    logic [WIDTH-1:0]                 dmem_wdata;
    logic [1:0][ADDRSIZE-1:0]         dmem_raddr;
    logic [1:0][WIDTH-1:0]            dmem_rdata;
    logic [0:0][ADDRSIZE-1:0]         imem_raddr;
    logic [0:0][WIDTH-1:0]            imem_rdata;

    assign ld_fire   = (state_q == ST_LOAD) && bus.ld_valid;
    assign dump_fire = (state_q == ST_DUMP) && bus.dump_ready;
    assign cpu_we    = (state_q == ST_RUN)  && bus.MEM_CTRL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (ld_fire && bus.ld_last) state_d = ST_RUN;
            ST_RUN:  if (bus.debuger == HALT_CODE) state_d = ST_DUMP;
            ST_DUMP: if (dump_fire && (dump_cnt_q == DUMP_LAST)) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        bus.ld_ready   = 1'b0;
        bus.cpu_hold   = 1'b0;
        bus.dump_valid = 1'b0;
        bus.halted     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                bus.ld_ready = 1'b1;
                bus.cpu_hold = 1'b1;
            end
            ST_DUMP: bus.dump_valid = 1'b1;
            ST_DONE: bus.halted     = 1'b1;
            default: ;
        endcase
    end

    // Load counters are per memory; the dump counter is re-zeroed throughout RUN
    // so DUMP always starts at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dld_cnt_q  <= '0;
            ild_cnt_q  <= '0;
            dump_cnt_q <= '0;
        end else begin
            if (ld_fire && !bus.ld_sel) dld_cnt_q <= dld_cnt_q + 1'b1;
            if (ld_fire &&  bus.ld_sel) ild_cnt_q <= ild_cnt_q + 1'b1;
            if (state_q == ST_RUN) begin
                dump_cnt_q <= '0;
            end else if (dump_fire) begin
                dump_cnt_q <= dump_cnt_q + 1'b1;
            end
        end
    end

    assign dmem_we    = (ld_fire && !bus.ld_sel) || cpu_we;
    assign dmem_waddr = (state_q == ST_LOAD) ? dld_cnt_q : bus.MEM_ADDR;
    assign dmem_wdata = (state_q == ST_LOAD) ? bus.ld_data : WIDTH'(bus.MEM_OUT);
    assign dmem_raddr[0] = bus.MEM_ADDR;
    assign dmem_raddr[1] = dump_cnt_q;

    assign imem_we       = ld_fire && bus.ld_sel;
    assign imem_raddr[0] = bus.INS_ADDR;

    cpu_mem_array #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .RD_PORTS(2)) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .waddr (dmem_waddr),
        .wdata (dmem_wdata),
        .raddr (dmem_raddr),
        .rdata (dmem_rdata)
    );

    cpu_mem_array #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .RD_PORTS(1)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (ild_cnt_q),
        .wdata (bus.ld_data),
        .raddr (imem_raddr),
        .rdata (imem_rdata)
    );

    assign bus.MEM_IN    = dmem_rdata[0];
    assign bus.INS_MEM   = imem_rdata[0];
    assign bus.dump_addr = dump_cnt_q;
    assign bus.dump_data = dmem_rdata[1];

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: load, run, halt/dump, wrap and reset.
module tb_cpu_mem_responder;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_mem [10];

    always #5 clk = ~clk;

    cpu_mem_responder_if #(.WIDTH(32), .ADDRSIZE(12)) bus ();

    cpu_mem_responder #(.WIDTH(32), .ADDRSIZE(12), .DUMP_WORDS(10), .HALT_CODE(7'd5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_word(input logic sel, input logic [31:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_sel   = sel;
        bus.ld_data  = data;
        bus.ld_last  = last;
        tick();
    endtask

    task automatic cpu_write(input logic [11:0] addr, input logic [31:0] data);
        bus.MEM_ADDR = addr;
        bus.MEM_OUT  = data;
        bus.MEM_CTRL = 1'b1;
        tick();
        bus.MEM_CTRL = 1'b0;
    endtask

    task automatic rd_dmem(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus.MEM_ADDR = addr;
        #1;
        chk(tag, bus.MEM_IN, exp);
    endtask

    task automatic rd_imem(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus.INS_ADDR = addr;
        #1;
        chk(tag, bus.INS_MEM, exp);
    endtask

    initial begin
        int acc;
        int cyc;
        bus.MEM_ADDR = '0; bus.MEM_OUT = '0; bus.MEM_CTRL = 1'b0; bus.INS_ADDR = '0;
        bus.debuger = '0; bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_data = '0;
        bus.ld_last = 1'b0; bus.dump_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_cpu_hold", bus.cpu_hold, 1);
        chk("rst_dump_valid", bus.dump_valid, 0);
        chk("rst_dump_addr", bus.dump_addr, 0);
        chk("rst_halted", bus.halted, 0);

        // Load two data words then two instruction words.
        ld_word(1'b0, 32'd7, 1'b0);
        ld_word(1'b0, 32'd9, 1'b0);
        ld_word(1'b1, 32'hA5A5_A5A5, 1'b0);
        chk("hold_before_last", bus.cpu_hold, 1);
        ld_word(1'b1, 32'h1, 1'b1);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        chk("hold_after_last", bus.cpu_hold, 0);
        chk("ld_ready_run", bus.ld_ready, 0);
        rd_dmem("dmem0", 12'd0, 32'd7);
        rd_dmem("dmem1", 12'd1, 32'd9);
        rd_imem("imem0", 12'd0, 32'hA5A5_A5A5);
        rd_imem("imem1", 12'd1, 32'h1);

        // Read-during-write on DMEM[3].
        cpu_write(12'd3, 32'd11);
        bus.MEM_ADDR = 12'd3; bus.MEM_OUT = 32'd42; bus.MEM_CTRL = 1'b1;
        #1;
        chk("rdw_old", bus.MEM_IN, 32'd11);
        tick();
        chk("rdw_new", bus.MEM_IN, 32'd42);
        bus.MEM_CTRL = 1'b0;
        tick();
        chk("rdw_hold", bus.MEM_IN, 32'd42);

        exp_mem[0] = 32'd99; exp_mem[1] = 32'd9; exp_mem[3] = 32'd42;
        for (int i = 2; i < 10; i++) begin
            if (i != 3) begin
                cpu_write(12'(i), 32'h100 + 32'(i));
                exp_mem[i] = 32'h100 + 32'(i);
            end
        end

        // Write and halt detect on the same edge.
        bus.MEM_ADDR = 12'd0; bus.MEM_OUT = 32'd99; bus.MEM_CTRL = 1'b1; bus.debuger = 7'd5;
        tick();
        bus.MEM_CTRL = 1'b0; bus.debuger = 7'd0;
        chk("dump_valid_entry", bus.dump_valid, 1);
        chk("dump_addr_entry", bus.dump_addr, 0);
        chk("dump_data_entry", bus.dump_data, 32'd99);

        // Stalling dump with CPU writes that must be ignored.
        acc = 0;
        cyc = 0;
        while (acc < 10 && cyc < 40) begin
            bus.dump_ready = (cyc % 2 == 0);
            bus.MEM_CTRL   = (cyc < 4);
            bus.MEM_ADDR   = 12'd7;
            bus.MEM_OUT    = 32'hDEAD;
            #1;
            chk("dump_valid", bus.dump_valid, 1);
            chk("dump_addr", bus.dump_addr, 64'(acc));
            chk("dump_data", bus.dump_data, exp_mem[acc]);
            tick();
            if (cyc % 2 == 0) acc++;
            cyc++;
        end
        bus.dump_ready = 1'b0;
        bus.MEM_CTRL   = 1'b0;
        chk("dump_accepts", 64'(acc), 10);
        chk("done_halted", bus.halted, 1);
        chk("done_dump_valid", bus.dump_valid, 0);
        rd_dmem("dump_write_ignored", 12'd7, 32'h107);

        // Wrap of the data load counter after 4096 words.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k <= 4096; k++) begin
            ld_word(1'b0, 32'h5000_0000 + 32'(k), k == 4096);
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        chk("wrap_hold", bus.cpu_hold, 0);
        rd_dmem("wrap_dmem0", 12'd0, 32'h5000_1000);
        rd_dmem("wrap_dmem1", 12'd1, 32'h5000_0001);
        rd_imem("imem_survives_rst", 12'd0, 32'hA5A5_A5A5);

        // Reset during a dump after four accepts.
        bus.debuger = 7'd5;
        tick();
        bus.debuger = 7'd0;
        chk("dump2_valid", bus.dump_valid, 1);
        bus.dump_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("dump2_addr", bus.dump_addr, 64'(i));
            chk("dump2_data", bus.dump_data, (i == 0) ? 32'h5000_1000 : 32'h5000_0000 + 32'(i));
            tick();
        end
        chk("dump2_addr4", bus.dump_addr, 4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_dump_valid", bus.dump_valid, 0);
        chk("async_cpu_hold", bus.cpu_hold, 1);
        chk("async_ld_ready", bus.ld_ready, 1);
        chk("async_dump_addr", bus.dump_addr, 0);
        bus.dump_ready = 1'b0;
        tick();
        rst = 1'b0;
        rd_dmem("post_rst_dmem0", 12'd0, 32'h5000_1000);
        rd_dmem("post_rst_dmem4", 12'd4, 32'h5000_0004);

        // Halt code and CPU writes outside RUN.
        bus.debuger = 7'd5;
        cpu_write(12'd4, 32'h0);
        bus.debuger = 7'd0;
        chk("load_ignores_halt", bus.cpu_hold, 1);
        chk("load_no_dump", bus.dump_valid, 0);
        rd_dmem("load_ignores_write", 12'd4, 32'h5000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
